// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX stage in front of the ALU.
// The stage captures the decoded op and the register operands. At capture it
// replaces operand b with the sign-extended immediate when in_use_imm is set.
// A main register drives the ALU outputs. A skid register holds one extra
// entry so that in_ready can be registered. Reset is async active-low, and
// flush clears all held entries synchronously.
// Optional feature: define ALU_OPERAND_FWD_EN to add write-back forwarding
// ports. At capture, matching forwarded data replaces operand a and/or b.
module alu_operand_stage #(
  parameter int WIDTH      = 32,
  parameter int OP_WIDTH   = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in_op,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [15:0]           in_imm,
  input  logic                  in_use_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
`ifdef ALU_OPERAND_FWD_EN
  input  logic                  fwd_we,
  input  logic [REG_ADDR_W-1:0] fwd_rd,
  input  logic [WIDTH-1:0]      fwd_data,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   op,
  output logic [WIDTH-1:0]      a,
  output logic [WIDTH-1:0]      b,
  output logic [REG_ADDR_W-1:0] rd
);

  logic                  main_valid_r;
  logic [OP_WIDTH-1:0]   main_op_r;
  logic [WIDTH-1:0]      main_a_r;
  logic [WIDTH-1:0]      main_b_r;
  logic [REG_ADDR_W-1:0] main_rd_r;

  logic                  skid_valid_r;
  logic [OP_WIDTH-1:0]   skid_op_r;
  logic [WIDTH-1:0]      skid_a_r;
  logic [WIDTH-1:0]      skid_b_r;
  logic [REG_ADDR_W-1:0] skid_rd_r;

  logic [WIDTH-1:0]      cap_a_s;
  logic [WIDTH-1:0]      cap_b_s;
  logic                  accept_s;
  logic                  send_s;
  logic                  load_main_s;
  logic                  load_skid_s;
  logic                  refill_s;

  // Operand values as they would be captured this cycle (imm select, forwarding)
  always_comb begin
    cap_a_s = in_a;
    if (in_use_imm) begin
      cap_b_s = {{(WIDTH-16){in_imm[15]}}, in_imm};
    end else begin
      cap_b_s = in_b;
    end
`ifdef ALU_OPERAND_FWD_EN
    if (fwd_we && (fwd_rd != {REG_ADDR_W{1'b0}}) && (fwd_rd == in_rs)) begin
      cap_a_s = fwd_data;
    end else begin
      cap_a_s = in_a;
    end
    if (fwd_we && (fwd_rd != {REG_ADDR_W{1'b0}}) && (fwd_rd == in_rt) && !in_use_imm) begin
      cap_b_s = fwd_data;
    end else begin
      cap_b_s = cap_b_s;
    end
`endif
  end

  // Decide where an accepted entry goes. Flush suppresses every move.
  always_comb begin
    accept_s    = in_valid & ~skid_valid_r;
    send_s      = main_valid_r & out_ready;
    load_main_s = 1'b0;
    load_skid_s = 1'b0;
    refill_s    = 1'b0;
    if (flush) begin
      load_main_s = 1'b0;
    end else if (skid_valid_r) begin
      // in_ready is low here, so only the skid-to-main move can happen
      refill_s = send_s;
    end else if (!main_valid_r || send_s) begin
      load_main_s = accept_s;
    end else begin
      load_skid_s = accept_s;
    end
  end

  // Valid flags: async reset, flush clears both, otherwise follow the moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else begin
      main_valid_r <= load_main_s | refill_s | (main_valid_r & ~send_s);
      skid_valid_r <= load_skid_s | (skid_valid_r & ~send_s);
    end
  end

  // Data registers: change only when an entry moves in, so outputs hold under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_op_r <= {OP_WIDTH{1'b0}};
      main_a_r  <= {WIDTH{1'b0}};
      main_b_r  <= {WIDTH{1'b0}};
      main_rd_r <= {REG_ADDR_W{1'b0}};
      skid_op_r <= {OP_WIDTH{1'b0}};
      skid_a_r  <= {WIDTH{1'b0}};
      skid_b_r  <= {WIDTH{1'b0}};
      skid_rd_r <= {REG_ADDR_W{1'b0}};
    end else begin
      if (refill_s) begin
        main_op_r <= skid_op_r;
        main_a_r  <= skid_a_r;
        main_b_r  <= skid_b_r;
        main_rd_r <= skid_rd_r;
      end else if (load_main_s) begin
        main_op_r <= in_op;
        main_a_r  <= cap_a_s;
        main_b_r  <= cap_b_s;
        main_rd_r <= in_rd;
      end
      if (load_skid_s) begin
        skid_op_r <= in_op;
        skid_a_r  <= cap_a_s;
        skid_b_r  <= cap_b_s;
        skid_rd_r <= in_rd;
      end
    end
  end

  assign in_ready  = ~skid_valid_r;
  assign out_valid = main_valid_r;
  assign op        = main_op_r;
  assign a         = main_a_r;
  assign b         = main_b_r;
  assign rd        = main_rd_r;

endmodule
